stream_mux_rr: RTL and testbench

//  Parametrised N:1 stream multiplexer with valid/ready handshake and one registered output stage.

---
 rtl/stream_mux_rr_if.sv | 54 +++++
 rtl/stream_mux_rr.sv | 143 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
//   Bundles the N producer streams and the single consumer stream of the
//   round-robin stream multiplexer.
//   Signals:
//     in_data   CHANNELS*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//     in_valid  CHANNELS        per-channel valid
//     in_ready  CHANNELS        per-channel ready (driven by the mux)
//     mode      1               0 = fixed select by s, 1 = round-robin
//     s         SEL_W           fixed-mode channel select
//     out_data  WIDTH           registered output data
//     out_valid 1               output beat present
//     out_ready 1               consumer accepts the output beat
//     out_chan  SEL_W           source channel of out_data
//     in_last / out_last        packet boundary, only with MUX_PKT_LOCK_EN
//   Modports: slave = the mux itself, master = the surrounding producers/consumer.
//   Optional feature macro: MUX_PKT_LOCK_EN.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          s;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;
`ifdef MUX_PKT_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
    logic                      out_last;

    modport slave (
        input  in_data, in_valid, mode, s, out_ready, in_last,
        output in_ready, out_data, out_valid, out_chan, out_last
    );
    modport master (
        output in_data, in_valid, mode, s, out_ready, in_last,
        input  in_ready, out_data, out_valid, out_chan, out_last
    );
`else
    modport slave (
        input  in_data, in_valid, mode, s, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
    modport master (
        output in_data, in_valid, mode, s, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N:1 stream multiplexer with valid/ready handshake and a single registered
//   output stage. Arbitration is either fixed (channel s) or round-robin
//   starting after the last granted channel.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high
//     bus   stream_mux_rr_if.slave (all data/handshake signals)
//   Optional feature macro: MUX_PKT_LOCK_EN
//     When defined, a transfer with in_last=0 locks arbitration onto that
//     channel until a transfer with in_last=1 ends the packet; out_last is
//     registered alongside out_data.
module stream_mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             out_last_q, out_last_d;
    logic             sel_last;
`endif

    logic             accept;
    logic             gnt_ok;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] cand;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    assign accept = !out_valid_q || bus.out_ready;

    // Round-robin walks forward from the channel after rr_ptr, wrapping at
    // CHANNELS-1 so non-power-of-2 channel counts never visit unused indices.
    always_comb begin
        grant  = '0;
        gnt_ok = 1'b0;
        cand   = rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
        if (lock_q) begin
            grant  = lock_ch_q;
            gnt_ok = 1'b1;
        end else
`endif
        if (!bus.mode) begin
            grant  = bus.s;
            gnt_ok = (32'(bus.s) < CHANNELS);
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cand = (cand == LAST_CH) ? '0 : cand + SEL_W'(1);
                if (!gnt_ok && bus.in_valid[cand]) begin
                    gnt_ok = 1'b1;
                    grant  = cand;
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
`ifdef MUX_PKT_LOCK_EN
        sel_last  = 1'b1;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_data  = bus.in_data[i*WIDTH +: WIDTH];
`ifdef MUX_PKT_LOCK_EN
                sel_last  = bus.in_last[i];
`endif
            end
        end
    end

    // in_ready is held low during reset so no producer sees a phantom handshake.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = !rst && accept && gnt_ok && (grant == SEL_W'(i));
        end
    end

    assign xfer = !rst && accept && gnt_ok && sel_valid;

    always_comb begin
        out_valid_d = accept ? xfer : out_valid_q;
        out_data_d  = xfer ? sel_data : out_data_q;
        out_chan_d  = xfer ? grant : out_chan_q;
        rr_ptr_d    = xfer ? grant : rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
        // Under lock the grant is always lock_ch, so any transfer carrying
        // in_last=1 is the one that ends the packet.
        lock_d      = xfer ? !sel_last : lock_q;
        lock_ch_d   = xfer ? grant : lock_ch_q;
        out_last_d  = xfer ? sel_last : out_last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            rr_ptr_q    <= LAST_CH;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
`ifdef MUX_PKT_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the single output slot plus arbitration memory.
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_chan;
    int               m_ptr;
    bit               m_lock;
    int               m_lock_ch;
    bit               m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_chan    = 0;
        m_ptr     = CHANNELS - 1;
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_last    = 1'b0;
    endtask

    function automatic void model_arb(output bit ok, output int g);
        int c;
        ok = 1'b0;
        g  = 0;
        if (m_lock) begin
            ok = 1'b1;
            g  = m_lock_ch;
        end else if (bus.mode == 1'b0) begin
            g  = int'(bus.s);
            ok = (g < CHANNELS);
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                c = (m_ptr + k) % CHANNELS;
                if (!ok && bus.in_valid[c]) begin
                    ok = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    // One clock: check everything at the falling edge, then advance the
    // model with the inputs that the DUT sees at the rising edge.
    task automatic tick();
        bit                  ok;
        int                  g;
        bit                  acc;
        logic [CHANNELS-1:0] exp_rdy;
        @(negedge clk);
        model_arb(ok, g);
        acc     = !m_valid || bus.out_ready;
        exp_rdy = '0;
        if (!rst && acc && ok) exp_rdy = CHANNELS'(1) << g;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_chan", 32'(bus.out_chan), 32'(m_chan));
`ifdef MUX_PKT_LOCK_EN
        chk("out_last", 32'(bus.out_last), 32'(m_last));
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (acc) begin
            if (ok && bus.in_valid[g]) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*WIDTH +: WIDTH];
                m_chan  = g;
                m_ptr   = g;
`ifdef MUX_PKT_LOCK_EN
                m_lock    = !bus.in_last[g];
                m_lock_ch = g;
                m_last    = bus.in_last[g];
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = '1;
        bus.mode      = 1'b0;
        bus.s         = '0;
        bus.out_ready = 1'b1;
`ifdef MUX_PKT_LOCK_EN
        bus.in_last   = '1;
`endif

        // Reset held two cycles with every channel valid.
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Fixed select of channel 3 while channel 0 is also valid.
        rst          = 1'b0;
        bus.mode     = 1'b0;
        bus.s        = 2'd3;
        bus.in_valid = 4'b1001;
        bus.in_data  = 16'hE005;
        #1;
        chk("fix_rdy0_pre", 32'(bus.in_ready[0]), 32'd0);
        tick();
        chk("fix_data", 32'(bus.out_data), 32'hE);
        chk("fix_chan", 32'(bus.out_chan), 32'd3);
        chk("fix_rdy0", 32'(bus.in_ready[0]), 32'd0);

        // Round-robin from reset with all channels valid.
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        bus.in_data  = 16'h7531;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_seq_chan", 32'(bus.out_chan), 32'(k % 4));
            chk("rr_seq_data", 32'(bus.out_data), 32'(2 * (k % 4) + 1));
        end

        // Backpressure: held beat from channel 0 must not move.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_data", 32'(bus.out_data), 32'h1);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("resume_chan1", 32'(bus.out_chan), 32'd1);
        chk("resume_data1", 32'(bus.out_data), 32'h3);
        tick();
        chk("resume_chan2", 32'(bus.out_chan), 32'd2);

        // Lone requester, then two requesters around the wrap.
        bus.in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lone_ch2", 32'(bus.out_chan), 32'd2);
        end
        bus.in_valid = 4'b0101;
        tick();
        chk("wrap_ch0", 32'(bus.out_chan), 32'd0);
        tick();
        chk("wrap_ch2", 32'(bus.out_chan), 32'd2);

`ifdef MUX_PKT_LOCK_EN
        // Packet lock: three beats from ch1 while ch2 keeps requesting.
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.mode     = 1'b1;
        bus.in_valid = 4'b0110;
        bus.in_last  = 4'b0100;
        tick();
        chk("lock_c0", 32'(bus.out_chan), 32'd1);
        chk("lock_l0", 32'(bus.out_last), 32'd0);
        tick();
        chk("lock_c1", 32'(bus.out_chan), 32'd1);
        chk("lock_l1", 32'(bus.out_last), 32'd0);
        bus.in_last = 4'b0110;
        tick();
        chk("lock_c2", 32'(bus.out_chan), 32'd1);
        chk("lock_l2", 32'(bus.out_last), 32'd1);
        bus.in_valid = 4'b0100;
        tick();
        chk("lock_c3", 32'(bus.out_chan), 32'd2);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            bus.in_valid  = CHANNELS'($urandom);
            bus.in_data   = (CHANNELS*WIDTH)'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
            bus.s         = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_PKT_LOCK_EN
            bus.in_last   = CHANNELS'($urandom);
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
